// File: rtl/mult_pkg.sv
// Shared types for the serial multiplier datapath: controller states and
// radix-2 Booth recoding operations.
package mult_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_ZERO = 2'd0,
        BOOTH_POS  = 2'd1,
        BOOTH_NEG  = 2'd2
    } booth_op_e;

    // Radix-2 Booth: the pair (b_i, b_prev) selects 0, +A or -A.
    function automatic booth_op_e booth_decode(input logic b_i, input logic b_prev);
        case ({b_i, b_prev})
            2'b01:   return BOOTH_POS;
            2'b10:   return BOOTH_NEG;
            default: return BOOTH_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_recode_cell.sv
// One radix-2 Booth step: turns a multiplier bit pair into a sign-extended
// partial product of the multiplicand.
module booth_recode_cell
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  b_i,
    input  logic                  b_prev,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    output logic [DATA_WIDTH:0]   term
);

    booth_op_e               op;
    logic [DATA_WIDTH:0]     a_ext;

    // The extra bit keeps -(-2^(N-1)) representable.
    assign a_ext = {multiplicand[DATA_WIDTH-1], multiplicand};
    assign op    = booth_decode(b_i, b_prev);

    always_comb begin
        term = '0;
        case (op)
            BOOTH_POS: term = a_ext;
            BOOTH_NEG: term = -a_ext;
            default:   term = '0;
        endcase
    end

endmodule

// File: rtl/booth_partial_product_generator.sv
// Sequential radix-2 Booth recoder: latches a signed operand pair and streams
// one partial product per accepted cycle, LSB step first, to the accumulator.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured and term 0 prepared on accept
//   RUN   | presenting term pp_index; advances on pp_ready, holds otherwise
//   DONE  | one-cycle done pulse after the last term was taken
module booth_partial_product_generator
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    input  logic                  pp_ready,
    output logic                  busy,
    output logic [DATA_WIDTH:0]   partial_product,
    output logic                  partial_product_valid,
    output logic [IDX_WIDTH-1:0]  pp_index,
    output logic                  pp_last,
    output logic                  done
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

    state_e                  state;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [IDX_WIDTH-1:0]    idx_next;

    logic                    cell_b_i;
    logic                    cell_b_prev;
    logic [DATA_WIDTH-1:0]   cell_a;
    logic [DATA_WIDTH:0]     cell_term;

    assign idx_next = pp_index + 1'b1;

    // In IDLE the cell looks at the live inputs so term 0 can be registered
    // on the accept edge; in RUN it prepares the next term from the latched
    // operands, so the output stays fully registered.
    always_comb begin
        cell_b_i    = b_reg[idx_next];
        cell_b_prev = b_reg[pp_index];
        cell_a      = a_reg;
        if (state == IDLE) begin
            cell_b_i    = multiplier[0];
            cell_b_prev = 1'b0;
            cell_a      = multiplicand;
        end
    end

    booth_recode_cell #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_recode (
        .b_i          (cell_b_i),
        .b_prev       (cell_b_prev),
        .multiplicand (cell_a),
        .term         (cell_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            a_reg                 <= '0;
            b_reg                 <= '0;
            busy                  <= 1'b0;
            partial_product       <= '0;
            partial_product_valid <= 1'b0;
            pp_index              <= '0;
            pp_last               <= 1'b0;
            done                  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state                 <= RUN;
                        a_reg                 <= multiplicand;
                        b_reg                 <= multiplier;
                        busy                  <= 1'b1;
                        partial_product       <= cell_term;
                        partial_product_valid <= 1'b1;
                        pp_index              <= '0;
                        pp_last               <= 1'b0;
                    end
                end
                RUN: begin
                    if (pp_ready) begin
                        if (pp_last) begin
                            state                 <= DONE;
                            busy                  <= 1'b0;
                            partial_product       <= '0;
                            partial_product_valid <= 1'b0;
                            pp_index              <= '0;
                            pp_last               <= 1'b0;
                            done                  <= 1'b1;
                        end else begin
                            partial_product <= cell_term;
                            pp_index        <= idx_next;
                            pp_last         <= (idx_next == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state                 <= IDLE;
                    busy                  <= 1'b0;
                    partial_product       <= '0;
                    partial_product_valid <= 1'b0;
                    pp_index              <= '0;
                    pp_last               <= 1'b0;
                    done                  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_partial_product_generator.sv
// Self-checking bench for the Booth partial product generator: directed and
// random operand pairs against an arithmetic model of the Booth terms.
module tb_booth_partial_product_generator;

    localparam int DW = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic            pp_ready;
    logic            busy;
    logic [DW:0]     partial_product;
    logic            partial_product_valid;
    logic [IW-1:0]   pp_index;
    logic            pp_last;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    booth_partial_product_generator #(
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .multiplicand          (multiplicand),
        .multiplier            (multiplier),
        .pp_ready              (pp_ready),
        .busy                  (busy),
        .partial_product       (partial_product),
        .partial_product_valid (partial_product_valid),
        .pp_index              (pp_index),
        .pp_last               (pp_last),
        .done                  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint pp_val();
        return longint'($signed(partial_product));
    endfunction

    // mode 0: pp_ready always 1; mode 1: 1,0,0 repeating; mode 2: random
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int mode, input bit poke);
        longint exp_t[DW];
        longint sum;
        longint bprev;
        int     n;
        int     cyc;
        bit     rdy;

        // Booth term i is (B[i-1] - B[i]) * A with B[-1] = 0
        bprev = 0;
        for (int i = 0; i < DW; i++) begin
            exp_t[i] = (bprev - longint'(b[i])) * longint'($signed(a));
            bprev    = longint'(b[i]);
        end

        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        pp_ready     = 1'b0;
        n   = 0;
        cyc = 0;
        sum = 0;
        while (n < DW && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start        = 1'b0;
            multiplicand = DW'($urandom);
            multiplier   = DW'($urandom);
            check_eq("busy", longint'(busy), 1);
            check_eq("valid", longint'(partial_product_valid), 1);
            check_eq("pp_index", longint'(pp_index), longint'(n));
            check_eq("pp_term", pp_val(), exp_t[n]);
            check_eq("pp_last", longint'(pp_last), longint'(n == DW - 1));
            check_eq("done_early", longint'(done), 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3) == 0;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            pp_ready = rdy;
            if (poke && n == 5) start = 1'b1;
            if (rdy) begin
                sum += pp_val() <<< n;
                n++;
            end
        end
        if (n < DW) check_eq("timeout_terms", longint'(n), longint'(DW));

        @(negedge clk);
        pp_ready = 1'(($urandom));
        start    = poke;
        check_eq("done_pulse", longint'(done), 1);
        check_eq("busy_done", longint'(busy), 0);
        check_eq("valid_done", longint'(partial_product_valid), 0);
        if (mode == 0) check_eq("done_latency", longint'(cyc + 1), longint'(DW + 1));
        check_eq("weighted_sum", sum, longint'($signed(a)) * longint'($signed(b)));

        @(negedge clk);
        start = 1'b0;
        check_eq("done_clear", longint'(done), 0);
        check_eq("idle_valid", longint'(partial_product_valid), 0);
        check_eq("idle_busy", longint'(busy), 0);
    endtask

    task automatic reset_mid_op();
        int guard;
        @(negedge clk);
        multiplicand = DW'($urandom);
        multiplier   = DW'($urandom);
        start        = 1'b1;
        pp_ready     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (pp_index != IW'(8) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_idx8", longint'(pp_index), 8);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_valid", longint'(partial_product_valid), 0);
        check_eq("rst_pp", pp_val(), 0);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_index", longint'(pp_index), 0);
        check_eq("rst_last", longint'(pp_last), 0);
        check_eq("rst_done", longint'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_done", longint'(done), 0);
            check_eq("post_rst_valid", longint'(partial_product_valid), 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        pp_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_valid", longint'(partial_product_valid), 0);
        check_eq("reset_busy", longint'(busy), 0);
        check_eq("reset_pp", pp_val(), 0);
        check_eq("reset_done", longint'(done), 0);
        reset = 1'b0;

        run_op(16'h0003, 16'h0005, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 0, 1'b0);
        run_op(16'h0100, 16'hFFFF, 0, 1'b0);
        run_op(16'h0007, 16'h000A, 1, 1'b0);
        run_op(16'h1234, 16'hBEEF, 0, 1'b1);
        run_op(16'h7FFF, 16'h8000, 2, 1'b0);
        reset_mid_op();
        run_op(16'hFFFF, 16'h5555, 0, 1'b0);
        for (int k = 0; k < 30; k++)
            run_op(DW'($urandom), DW'($urandom), 2, k[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
